// File: rtl/spi_read_adc_avg_if.sv
// Bus bundle for the averaging SPI ADC reader: start request, SPI pins,
// status and averaged result.
interface spi_read_adc_avg_if #(
  parameter int DATA_W = 12
);
  logic              strr_i;
  logic              slow_clk_i;
  logic              miso_i;
  logic              cs_n_o;
  logic              busy_o;
  logic [DATA_W-1:0] dout_o;
  logic              eor_o;

  modport master (
    output strr_i, slow_clk_i, miso_i,
    input  cs_n_o, busy_o, dout_o, eor_o
  );

  modport slave (
    input  strr_i, slow_clk_i, miso_i,
    output cs_n_o, busy_o, dout_o, eor_o
  );
endinterface

// File: rtl/spi_read_adc_avg.sv
// Reads 2^AVG_LOG2 SPI frames, extracts a data field from each and outputs their mean.
// Optional macro SPI_ADC_ROUND_EN: round-half-up with saturation instead of truncation.
module spi_read_adc_avg #(
  parameter int FRAME_W  = 16,
  parameter int DATA_W   = 12,
  parameter int LSB_POS  = 4,
  parameter int AVG_LOG2 = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  spi_read_adc_avg_if.slave   bus
);

  localparam int AW   = DATA_W + AVG_LOG2;
  localparam int SW   = LSB_POS + DATA_W;
  localparam int CW   = $clog2(FRAME_W + 1);
  localparam int FCW  = AVG_LOG2 + 1;
  localparam int HALF = (2 ** AVG_LOG2) / 2;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SHIFT, S_ACC, S_GAP, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              slow_q;
  logic              rise, fall;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [FCW-1:0]    frm_cnt_q, frm_cnt_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              gap_rise_q, gap_rise_d;
  logic [SW-1:0]     shreg_q, shreg_d;
  logic              cs_n, busy, eor;

  function automatic logic [DATA_W-1:0] avg_f(input logic [AW-1:0] acc);
`ifdef SPI_ADC_ROUND_EN
    logic [AW:0] sum;
    sum = {1'b0, acc} + (AW+1)'(HALF);
    sum = sum >> AVG_LOG2;
    if (|sum[AW:DATA_W]) return '1;
    return sum[DATA_W-1:0];
`else
    logic [AW-1:0] q;
    q = acc >> AVG_LOG2;
    return q[DATA_W-1:0];
`endif
  endfunction

  assign rise = bus.slow_clk_i & ~slow_q;
  assign fall = ~bus.slow_clk_i & slow_q;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    frm_cnt_d  = frm_cnt_q;
    acc_d      = acc_q;
    dout_d     = dout_q;
    gap_rise_d = gap_rise_q;
    shreg_d    = shreg_q;
    cs_n       = 1'b1;
    busy       = 1'b1;
    eor        = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (bus.strr_i) begin
          acc_d     = '0;
          frm_cnt_d = '0;
          state_d   = S_SETUP;
        end
      end
      S_SETUP: begin
        cs_n = 1'b0;
        if (fall) begin
          bit_cnt_d = '0;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        cs_n = 1'b0;
        if (rise) begin
          // Bits above the field simply fall off the top of the register.
          shreg_d   = (shreg_q << 1) | SW'(bus.miso_i);
          bit_cnt_d = bit_cnt_q + CW'(1);
          if (bit_cnt_q == CW'(FRAME_W - 1)) state_d = S_ACC;
        end
      end
      S_ACC: begin
        acc_d      = acc_q + AW'(shreg_q[SW-1:LSB_POS]);
        frm_cnt_d  = frm_cnt_q + FCW'(1);
        gap_rise_d = 1'b0;
        state_d    = (frm_cnt_d == FCW'(2 ** AVG_LOG2)) ? S_DONE : S_GAP;
      end
      S_GAP: begin
        if (rise) gap_rise_d = 1'b1;
        if (fall && gap_rise_q) begin
          bit_cnt_d = '0;
          state_d   = S_SHIFT;
        end
      end
      S_DONE: begin
        eor     = 1'b1;
        dout_d  = avg_f(acc_q);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      slow_q     <= 1'b0;
      bit_cnt_q  <= '0;
      frm_cnt_q  <= '0;
      acc_q      <= '0;
      dout_q     <= '0;
      gap_rise_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      slow_q     <= bus.slow_clk_i;
      bit_cnt_q  <= bit_cnt_d;
      frm_cnt_q  <= frm_cnt_d;
      acc_q      <= acc_d;
      dout_q     <= dout_d;
      gap_rise_q <= gap_rise_d;
    end
  end

  // Shift register holds only data; every frame refills it completely.
  always_ff @(posedge clk_i) begin
    shreg_q <= shreg_d;
  end

  assign bus.cs_n_o = cs_n;
  assign bus.busy_o = busy;
  assign bus.eor_o  = eor;
  assign bus.dout_o = dout_q;

endmodule

// File: tb/tb_spi_read_adc_avg.sv
// Bench for spi_read_adc_avg: an averaging instance (AVG_LOG2=2) and a single-frame
// instance (AVG_LOG2=0) share one slow clock; each has its own ADC model.
module tb_spi_read_adc_avg;
  localparam int FW  = 16;
  localparam int DW  = 12;
  localparam int LSB = 4;

  logic clk, rst, slow;
  logic strr_a, strr_b;
  logic miso_v [2];
  logic cs_v [2], busy_v [2], eor_v [2];
  logic [DW-1:0] dout_v [2];

  spi_read_adc_avg_if #(.DATA_W(DW)) bus_a ();
  spi_read_adc_avg_if #(.DATA_W(DW)) bus_b ();

  spi_read_adc_avg #(.FRAME_W(FW), .DATA_W(DW), .LSB_POS(LSB), .AVG_LOG2(2)) dut_a (
    .clk_i(clk), .rst_i(rst), .bus(bus_a));
  spi_read_adc_avg #(.FRAME_W(FW), .DATA_W(DW), .LSB_POS(LSB), .AVG_LOG2(0)) dut_b (
    .clk_i(clk), .rst_i(rst), .bus(bus_b));

  assign bus_a.strr_i = strr_a;
  assign bus_b.strr_i = strr_b;
  assign bus_a.slow_clk_i = slow;
  assign bus_b.slow_clk_i = slow;
  assign bus_a.miso_i = miso_v[0];
  assign bus_b.miso_i = miso_v[1];
  assign cs_v[0] = bus_a.cs_n_o;   assign cs_v[1] = bus_b.cs_n_o;
  assign busy_v[0] = bus_a.busy_o; assign busy_v[1] = bus_b.busy_o;
  assign eor_v[0] = bus_a.eor_o;   assign eor_v[1] = bus_b.eor_o;
  assign dout_v[0] = bus_a.dout_o; assign dout_v[1] = bus_b.dout_o;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Slow SPI clock: 6 clk cycles per half period.
  initial begin
    slow = 1'b0;
    forever begin
      repeat (6) @(posedge clk);
      #1 slow = ~slow;
    end
  end

  // ADC model: drives the next bit after each falling SCLK edge, restarts on CS high.
  logic [15:0] frm [2][16];
  int load_gen [2];
  int seen_gen [2];
  int fptr [2];
  int nrise [2];
  logic acs_prev [2];
  logic aslow_prev;

  initial begin
    aslow_prev = 1'b0;
    for (int i = 0; i < 2; i++) begin
      acs_prev[i] = 1'b1; fptr[i] = 0; nrise[i] = 0; miso_v[i] = 1'b0; seen_gen[i] = 0;
    end
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < 2; i++) begin
        if (seen_gen[i] != load_gen[i]) begin
          seen_gen[i] = load_gen[i];
          fptr[i] = 0;
        end
        if (cs_v[i] === 1'b1) begin
          if (acs_prev[i] === 1'b0 && fptr[i] < 15) fptr[i]++;
          nrise[i] = 0;
          miso_v[i] = frm[i][fptr[i]][15];
        end else begin
          if (slow && !aslow_prev) nrise[i]++;
          else if (!slow && aslow_prev && nrise[i] < 16) miso_v[i] = frm[i][fptr[i]][15 - nrise[i]];
        end
        acs_prev[i] = cs_v[i];
      end
      aslow_prev = slow;
    end
  end

  // Protocol monitor: sampling edges per CS-low window, slow clock activity in gaps, eor count.
  logic mon_en;
  int bits [2], hi_r [2], hi_f [2], eor_cnt [2];
  logic hi_valid [2], pcs [2];
  logic mslow;
  int bad_bits, bad_gap, frames_chk, gaps_chk;

  initial begin
    mslow = 1'b0; bad_bits = 0; bad_gap = 0; frames_chk = 0; gaps_chk = 0;
    for (int i = 0; i < 2; i++) begin
      bits[i] = 0; hi_r[i] = 0; hi_f[i] = 0; eor_cnt[i] = 0; hi_valid[i] = 1'b0; pcs[i] = 1'b1;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (cs_v[i] === 1'b0 && pcs[i] === 1'b1) begin
          if (mon_en && hi_valid[i]) begin
            gaps_chk++;
            if (hi_r[i] < 1 || hi_f[i] < 1) begin
              bad_gap++;
              $display("dut %0d gap rises=%0d falls=%0d", i, hi_r[i], hi_f[i]);
            end
          end
          bits[i] = 0;
        end
        if (cs_v[i] === 1'b1 && pcs[i] === 1'b0) begin
          if (mon_en) begin
            frames_chk++;
            if (bits[i] != FW) begin
              bad_bits++;
              $display("dut %0d frame had %0d sampling edges", i, bits[i]);
            end
          end
          hi_valid[i] = busy_v[i];
          hi_r[i] = 0;
          hi_f[i] = 0;
        end
        if (cs_v[i] === 1'b0 && slow && !mslow) bits[i]++;
        if (cs_v[i] === 1'b1) begin
          if (slow && !mslow) hi_r[i]++;
          if (!slow && mslow) hi_f[i]++;
        end
        if (busy_v[i] !== 1'b1) hi_valid[i] = 1'b0;
        if (eor_v[i] === 1'b1) eor_cnt[i]++;
        pcs[i] = cs_v[i];
      end
      mslow = slow;
    end
  end

  int checks, errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference: mean of the extracted fields, by plain integer arithmetic.
  function automatic int model_avg(input int i, input int base, input int n);
    int sum;
    int r;
    sum = 0;
    for (int k = 0; k < n; k++) sum += int'((frm[i][base+k] >> LSB) & 16'h0FFF);
`ifdef SPI_ADC_ROUND_EN
    if (n > 1) begin
      r = (sum + n / 2) / n;
      if (r > 4095) r = 4095;
      return r;
    end
`endif
    r = sum / n;
    return r;
  endfunction

  task automatic set_strr(input int i, input logic v);
    if (i == 0) strr_a = v;
    else strr_b = v;
  endtask

  task automatic start_read(input int i, input bit hold);
    int n;
    n = 0;
    while (slow && n < 100) begin @(negedge clk); n++; end
    while (!slow && n < 100) begin @(negedge clk); n++; end
    set_strr(i, 1'b1);
    @(negedge clk);
    if (!hold) set_strr(i, 1'b0);
  endtask

  task automatic wait_eor(input int i, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (eor_v[i] === 1'b1) begin ok = 1'b1; break; end
    end
    chk("eor_seen", 32'(ok), 1);
  endtask

  task automatic do_read(input int i, input int exp, input string name);
    bit ok;
    start_read(i, 1'b0);
    wait_eor(i, 3000, ok);
    @(negedge clk);
    chk(name, 32'(dout_v[i]), exp);
    chk("eor_one_cycle", 32'(eor_v[i]), 0);
    chk("idle_after_done", 32'(busy_v[i]), 0);
  endtask

  task automatic wait_in_frame2();
    bit hit;
    hit = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (fptr[0] >= 1 && cs_v[0] === 1'b0) begin hit = 1'b1; break; end
    end
    chk("reached_frame2", 32'(hit), 1);
    repeat (40) @(negedge clk);
  endtask

  typedef struct packed {
    logic [3:0][15:0] f;
    logic [11:0]      exp_t;
    logic [11:0]      exp_r;
  } vec_t;

  vec_t tbl [5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp, e0, n, last_exp;
    bit ok;
    tbl[0] = '{f: {16'h0675, 16'h0662, 16'h0658, 16'h0643}, exp_t: 12'd101,  exp_r: 12'd102};
    tbl[1] = '{f: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, exp_t: 12'hFFF,  exp_r: 12'hFFF};
    tbl[2] = '{f: {16'h0000, 16'h0000, 16'h0000, 16'h0000}, exp_t: 12'd0,    exp_r: 12'd0};
    tbl[3] = '{f: {16'h0003, 16'h000F, 16'h001A, 16'h001F}, exp_t: 12'd0,    exp_r: 12'd1};
    tbl[4] = '{f: {16'hFFE7, 16'hFFFE, 16'hFFF1, 16'hFFF0}, exp_t: 12'd4094, exp_r: 12'd4095};
    checks = 0; errors = 0; mon_en = 1'b1;
    strr_a = 1'b0; strr_b = 1'b0; rst = 1'b1;
    load_gen[0] = 0; load_gen[1] = 0;
    for (int i = 0; i < 2; i++) for (int k = 0; k < 16; k++) frm[i][k] = 16'h0;

    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_cs_n", 32'(cs_v[i]), 1);
      chk("reset_busy", 32'(busy_v[i]), 0);
      chk("reset_eor", 32'(eor_v[i]), 0);
      chk("reset_dout", 32'(dout_v[i]), 0);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single-frame instance.
    frm[1][0] = 16'hABC5; load_gen[1]++;
    do_read(1, 12'hABC, "single_frame_abc");
    for (int r = 0; r < 3; r++) begin
      frm[1][0] = 16'($urandom); load_gen[1]++;
      do_read(1, model_avg(1, 0, 1), "single_frame_rand");
    end

    // Averaging instance: directed table.
    for (int v = 0; v < 5; v++) begin
      for (int k = 0; k < 4; k++) frm[0][k] = tbl[v].f[k];
      load_gen[0]++;
`ifdef SPI_ADC_ROUND_EN
      exp = int'(tbl[v].exp_r);
`else
      exp = int'(tbl[v].exp_t);
`endif
      do_read(0, exp, "avg_table");
    end

    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 4; k++) frm[0][k] = 16'($urandom);
      load_gen[0]++;
      do_read(0, model_avg(0, 0, 4), "avg_rand");
    end

    // Start request during the second frame must be ignored.
    for (int k = 0; k < 4; k++) frm[0][k] = 16'($urandom);
    load_gen[0]++;
    e0 = eor_cnt[0];
    start_read(0, 1'b0);
    wait_in_frame2();
    strr_a = 1'b1;
    @(negedge clk);
    strr_a = 1'b0;
    wait_eor(0, 3000, ok);
    @(negedge clk);
    chk("strr_ignored_dout", 32'(dout_v[0]), model_avg(0, 0, 4));
    last_exp = model_avg(0, 0, 4);
    repeat (1500) @(negedge clk);
    chk("strr_ignored_eor_count", 32'(eor_cnt[0] - e0), 1);
    chk("strr_ignored_frames", 32'(fptr[0]), 4);
    chk("strr_ignored_idle", 32'(busy_v[0]), 0);

    // Start request held high for three back-to-back reads.
    for (int k = 0; k < 12; k++) frm[0][k] = 16'($urandom);
    load_gen[0]++;
    start_read(0, 1'b1);
    n = 0;
    for (int c = 0; c < 8000 && n < 3; c++) begin
      @(negedge clk);
      if (eor_v[0] === 1'b1) begin
        chk("held_dout_stable", 32'(dout_v[0]), last_exp);
        if (n == 2) strr_a = 1'b0;
        @(negedge clk);
        chk("held_idle_cycle", 32'(busy_v[0]), 0);
        chk("held_dout", 32'(dout_v[0]), model_avg(0, 4 * n, 4));
        last_exp = model_avg(0, 4 * n, 4);
        n++;
        if (n < 3) begin
          @(negedge clk);
          chk("held_restart", 32'(busy_v[0]), 1);
        end
      end
    end
    strr_a = 1'b0;
    chk("held_reads", 32'(n), 3);
    repeat (20) @(negedge clk);

    // Reset in the middle of a read.
    for (int k = 0; k < 4; k++) frm[0][k] = tbl[0].f[k];
    load_gen[0]++;
    start_read(0, 1'b0);
    wait_in_frame2();
    chk("pre_reset_in_shift", 32'(cs_v[0]), 0);
    mon_en = 1'b0;
    e0 = eor_cnt[0];
    rst = 1'b1;
    @(negedge clk);
    chk("midread_reset_cs_n", 32'(cs_v[0]), 1);
    chk("midread_reset_busy", 32'(busy_v[0]), 0);
    chk("midread_reset_eor", 32'(eor_v[0]), 0);
    chk("midread_reset_dout", 32'(dout_v[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (1500) @(negedge clk);
    chk("midread_no_eor", 32'(eor_cnt[0] - e0), 0);
    chk("midread_stays_idle", 32'(busy_v[0]), 0);
    chk("midread_cs_high", 32'(cs_v[0]), 1);

    chk("frame_bit_count_violations", 32'(bad_bits), 0);
    chk("frames_observed", 32'(frames_chk > 20), 1);
    chk("gap_violations", 32'(bad_gap), 0);
    chk("gaps_observed", 32'(gaps_chk > 10), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_read_adc_avg.md
Name: spi_read_adc_avg

Overview:
- Parametrised successor of the single-frame SPI ADC read path.
- Captures 2^AVG_LOG2 consecutive SPI frames from the ADC on miso_i and extracts a configurable data field from each frame.
- Accumulates the fields and outputs the averaged sample with a one-cycle end-of-read pulse.
- Drives its own chip-select. Sits between the slow-clock divider and the TX/storage logic, in place of the single-frame reader.

Parameters:
- FRAME_W, 16: SPI frame length in bits, MSB first; range 2..32.
- DATA_W, 12: width of the extracted data field; DATA_W+LSB_POS <= FRAME_W.
- LSB_POS, 4: bit index of the field LSB within the frame; field = frame[LSB_POS+DATA_W-1:LSB_POS].
- AVG_LOG2, 2: log2 of frames per read; range 0..6. 0 gives a single-frame read.

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  synchronous, active-high reset.
- strr_i  input  1  start-read request, sampled each clk_i cycle.
- slow_clk_i  input  1  SPI serial clock from the divider, synchronous to clk_i. The same level drives the ADC SCLK.
- miso_i  input  1  ADC serial data.
- cs_n_o  output  1  ADC chip select, active low.
- busy_o  output  1  high while a read is in progress.
- dout_o  output  DATA_W  averaged sample, registered.
- eor_o  output  1  end-of-read pulse, one clk_i cycle.

Behaviour:
- Single clock clk_i. Reset is synchronous and active-high on rst_i. All state is registered on the rising edge of clk_i.
- Reset values: cs_n_o=1, busy_o=0, eor_o=0, dout_o=0. Internally: accumulator=0, bit counter=0, frame counter=0, state=IDLE, slow_clk_i history register=0.
- Edge detect:
  - rise = slow_clk_i & ~slow_q; fall = ~slow_clk_i & slow_q.
  - slow_q is slow_clk_i delayed one clk_i cycle.
- States IDLE, SETUP, SHIFT, ACC, GAP, DONE:
  - IDLE: cs_n_o=1, busy_o=0. On strr_i=1: clear accumulator and frame counter, go to SETUP. busy_o=1 from the next cycle. strr_i is ignored in every state except IDLE.
  - SETUP: cs_n_o=0. Wait for fall, then go to SHIFT with bit counter=0. This aligns the first sample to a full slow clock.
  - SHIFT: cs_n_o=0. On each rise, shift miso_i into the LSB of a FRAME_W shift register and increment the bit counter. When the bit counter reaches FRAME_W, go to ACC.
  - ACC (1 cycle): cs_n_o=1. Add the field (zero-extended) to the accumulator of width DATA_W+AVG_LOG2. Increment the frame counter.
    - Frame counter = 2^AVG_LOG2: go to DONE.
    - Otherwise: go to GAP.
  - GAP: cs_n_o=1. Wait for one rise followed by one fall, giving at least one full slow-clock period with CS high. Then go to SHIFT with bit counter=0 and cs_n_o=0.
  - DONE (1 cycle): dout_o <= accumulator >> AVG_LOG2 (truncation). eor_o=1 in this same cycle; the new dout_o is visible from the following cycle. busy_o=1 during DONE. Next state is IDLE.
- Accumulator cannot overflow at any parameter set, since all-ones fields sum to (2^DATA_W-1)*2^AVG_LOG2.
- dout_o holds its value between reads. It changes only in DONE or on reset.
- rise and fall in the same cycle is impossible by construction.
- rst_i asserted mid-read: next cycle all outputs return to reset values with no eor_o pulse. The partial frame is discarded.
- strr_i held high continuously starts a new read on the cycle after DONE returns to IDLE.
- Latency: strr_i to cs_n_o low = 1 clk_i cycle.

Optional Feature:
- Macro: SPI_ADC_ROUND_EN.
- Defined and AVG_LOG2>0: DONE computes (accumulator + 2^(AVG_LOG2-1)) >> AVG_LOG2, round-half-up. The sum is widened by 1 bit, and the result saturates at 2^DATA_W-1.
- Not defined, or AVG_LOG2=0: truncation as above, and no rounding logic is synthesised.

Test Plan:
- Reset: assert rst_i for 2 cycles during SHIFT -> cs_n_o=1, busy_o=0, eor_o=0, dout_o=0 on the next cycle; no eor_o pulse follows.
- AVG_LOG2=0, frame 0xABC5 on miso_i MSB first -> exactly 16 rise samples with cs_n_o low; eor_o pulses once; dout_o=0xABC.
- AVG_LOG2=2, fields 100,101,102,103 -> 4 frames, each separated by cs_n_o high for >=1 slow period. dout_o=101 without the macro; dout_o=102 with SPI_ADC_ROUND_EN.
- AVG_LOG2=2, four frames of 0xFFFF -> dout_o=0xFFF both with and without the macro (no overflow, saturation holds).
- strr_i pulsed during SHIFT of frame 2 -> ignored: one eor_o only, frame count stays 4.
- strr_i held high for 3 reads -> three eor_o pulses, each followed by an IDLE cycle. dout_o is stable between pulses.
